// File: rtl/sd_frame_deserializer_pkg.sv
// ----------------------------------------------------------------------------
// sd_frame_deserializer_pkg
//   Shared definitions for the SD host frame deserializer:
//   - FSM state encoding (2 bits)
//   - default geometry parameters (MAX_BITS / LANES / LEN_W)
//   - standard SD frame-length constants
// ----------------------------------------------------------------------------
package sd_frame_deserializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_SHIFT      = 2'd2,
        ST_DONE       = 2'd3
    } deser_state_t;

    localparam int DEF_MAX_BITS = 136;
    localparam int DEF_LANES    = 4;
    localparam int DEF_LEN_W    = 8;

    // SD frame lengths: 48-bit command/short response, 136-bit R2 response,
    // and beats for one 512-byte data block on 1 lane and on 4 lanes.
    localparam int CMD_FRAME_BITS     = 48;
    localparam int R2_FRAME_BITS      = 136;
    localparam int BLOCK_BEATS_1_LANE = 512 * 8;
    localparam int BLOCK_BEATS_4_LANE = 512 * 8 / 4;

endpackage

// File: rtl/sd_frame_deserializer_beat_counter.sv
// ----------------------------------------------------------------------------
// deser_beat_counter
//   Counts captured beats and flags the terminal beat of a frame.
//   Ports:
//     clk, reset  rising-edge clock, synchronous active-high reset
//     load        clear the count and latch limit (frame length in beats)
//     limit       frame length in beats, sampled only on load
//     inc         one beat is being captured this edge
//     last_beat   the beat being captured now is the final one of the frame
// ----------------------------------------------------------------------------
module deser_beat_counter #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [LEN_W-1:0] limit,
    input  logic             inc,
    output logic             last_beat
);

    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] limit_q;
    logic [LEN_W-1:0] count_inc;

    // count_q < limit_q whenever a beat is taken, so the increment cannot wrap.
    assign count_inc = count_q + 1'b1;
    assign last_beat = (count_inc == limit_q);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            limit_q <= '0;
        end else if (load) begin
            count_q <= '0;
            limit_q <= limit;
        end else if (inc) begin
            count_q <= count_inc;
        end
    end

endmodule

// File: rtl/sd_frame_deserializer.sv
// ----------------------------------------------------------------------------
// sd_frame_deserializer
//   Serial-to-parallel capture for SD CMD/DAT paths. Shifts in 1 lane or LANES
//   lanes per beat, MSB first, optionally after a start bit, for framesize
//   beats; then holds the frame with complete high until enable drops.
//   Ports:
//     clk, reset   rising-edge clock, synchronous active-high reset
//     enable       run/pause; deassert in DONE to release the frame
//     lane_mode    0 = in[0] only, 1 = LANES lanes per beat (sampled in IDLE)
//     wait_start   1 = hunt for in[0]==0 before capture (sampled in IDLE)
//     framesize    beats per frame (sampled in IDLE)
//     in           serial lanes; in[0] is CMD/DAT0, in[LANES-1] is the MSB
//     out          captured frame, right-aligned
//     busy         registered, high in WAIT_START or SHIFT
//     complete     registered, high in DONE
// ----------------------------------------------------------------------------
module sd_frame_deserializer
    import sd_frame_deserializer_pkg::*;
#(
    parameter int MAX_BITS = DEF_MAX_BITS,
    parameter int LANES    = DEF_LANES,
    parameter int LEN_W    = DEF_LEN_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                lane_mode,
    input  logic                wait_start,
    input  logic [LEN_W-1:0]    framesize,
    input  logic [LANES-1:0]    in,
    output logic [MAX_BITS-1:0] out,
    output logic                busy,
    output logic                complete
);

    deser_state_t        state_q, state_d;
    logic [MAX_BITS-1:0] out_q, out_d;
    logic                wide_q, wide_d;
    logic                cnt_load, cnt_inc, cnt_last;

    deser_beat_counter #(.LEN_W(LEN_W)) u_beat_counter (
        .clk       (clk),
        .reset     (reset),
        .load      (cnt_load),
        .limit     (framesize),
        .inc       (cnt_inc),
        .last_beat (cnt_last)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        wide_d   = wide_q;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    out_d    = '0;
                    wide_d   = lane_mode;
                    cnt_load = 1'b1;
                    if (framesize == '0)
                        state_d = ST_DONE;
                    else if (wait_start)
                        state_d = ST_WAIT_START;
                    else
                        state_d = ST_SHIFT;
                end
            end
            ST_WAIT_START: begin
                // The start bit only triggers capture; it is never shifted in.
                if (enable && !in[0])
                    state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (enable) begin
                    cnt_inc = 1'b1;
                    if (wide_q)
                        out_d = {out_q[MAX_BITS-LANES-1:0], in};
                    else
                        out_d = {out_q[MAX_BITS-2:0], in[0]};
                    if (cnt_last)
                        state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!enable)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // busy/complete are decoded from the next state and registered so they
    // change exactly with the state register and never glitch.
    // NOTE: out_q is a datapath register that must read 0 after reset, so it
    // is reset along with the control state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            out_q    <= '0;
            wide_q   <= 1'b0;
            busy     <= 1'b0;
            complete <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            wide_q   <= wide_d;
            busy     <= (state_d == ST_WAIT_START) || (state_d == ST_SHIFT);
            complete <= (state_d == ST_DONE);
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_sd_frame_deserializer.sv
// ----------------------------------------------------------------------------
// tb_sd_frame_deserializer
//   Directed bench for sd_frame_deserializer with default parameters
//   (MAX_BITS=136, LANES=4, LEN_W=8). Inputs change 1 time unit after each
//   rising edge; outputs are checked at the same point.
// ----------------------------------------------------------------------------
module tb_sd_frame_deserializer;

    localparam int MAX_BITS = 136;
    localparam int LANES    = 4;
    localparam int LEN_W    = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic                lane_mode;
    logic                wait_start;
    logic [LEN_W-1:0]    framesize;
    logic [LANES-1:0]    din;
    logic [MAX_BITS-1:0] out;
    logic                busy;
    logic                complete;

    int checks = 0;
    int errors = 0;

    logic [MAX_BITS-1:0] pat;
    logic                busy_ok;

    always #5 clk = ~clk;

    sd_frame_deserializer #(
        .MAX_BITS (MAX_BITS),
        .LANES    (LANES),
        .LEN_W    (LEN_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .lane_mode  (lane_mode),
        .wait_start (wait_start),
        .framesize  (framesize),
        .in         (din),
        .out        (out),
        .busy       (busy),
        .complete   (complete)
    );

    task automatic check(input string tag, input logic [MAX_BITS-1:0] obs,
                         input logic [MAX_BITS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        din = {3'b000, b};
        step();
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        lane_mode  = 1'b0;
        wait_start = 1'b0;
        framesize  = '0;
        din        = '0;
        step();
        step();
        check("reset_out", out, '0);
        check("reset_busy", {135'd0, busy}, 136'd0);
        check("reset_complete", {135'd0, complete}, 136'd0);

        // ---- 1-lane, 12 bits, no start bit: 0xAB5 ----
        reset     = 1'b0;
        enable    = 1'b1;
        framesize = 8'd12;
        step();
        check("t1_busy_start", {135'd0, busy}, 136'd1);
        pat = 136'hAB5;
        for (int i = 11; i >= 0; i--) begin
            send_bit(pat[i]);
            if (i == 1) check("t1_not_done_11", {135'd0, complete}, 136'd0);
        end
        check("t1_complete", {135'd0, complete}, 136'd1);
        check("t1_busy_done", {135'd0, busy}, 136'd0);
        check("t1_out", out, 136'hAB5);
        enable = 1'b0;
        step();
        check("t1_release", {135'd0, complete}, 136'd0);
        check("t1_out_held", out, 136'hAB5);

        // ---- 1-lane, start bit hunt, 48-bit CMD ----
        wait_start = 1'b1;
        framesize  = 8'd48;
        enable     = 1'b1;
        din        = 4'hF;
        step();
        check("t2_busy_wait", {135'd0, busy}, 136'd1);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        check("t2_still_wait_busy", {135'd0, busy}, 136'd1);
        check("t2_still_wait_cmp", {135'd0, complete}, 136'd0);
        send_bit(1'b0);
        check("t2_start_not_captured", out, '0);
        pat     = 136'h40_0000_0000_95;
        busy_ok = 1'b1;
        for (int i = 47; i >= 0; i--) begin
            send_bit(pat[i]);
            if (i != 0) busy_ok = busy_ok & busy;
        end
        check("t2_busy_throughout", {135'd0, busy_ok}, 136'd1);
        check("t2_complete", {135'd0, complete}, 136'd1);
        check("t2_out", out, 136'h40_0000_0000_95);
        enable     = 1'b0;
        wait_start = 1'b0;
        step();

        // ---- wide mode, 4 nibbles DEAD; config changed mid-frame ----
        lane_mode = 1'b1;
        framesize = 8'd4;
        enable    = 1'b1;
        step();
        lane_mode  = 1'b0;
        framesize  = 8'd9;
        wait_start = 1'b1;
        din = 4'hD; step();
        din = 4'hE; step();
        din = 4'hA; step();
        din = 4'hD; step();
        check("t3_complete", {135'd0, complete}, 136'd1);
        check("t3_out", out, 136'hDEAD);
        enable     = 1'b0;
        wait_start = 1'b0;
        step();

        // ---- pause for 3 cycles mid-SHIFT ----
        framesize = 8'd12;
        enable    = 1'b1;
        step();
        pat = 136'hAB5;
        for (int i = 11; i >= 7; i--) send_bit(pat[i]);
        check("t4_before_pause", out, 136'h15);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din = ~din;
            step();
            check("t4_pause_out", out, 136'h15);
            check("t4_pause_busy", {135'd0, busy}, 136'd1);
            check("t4_pause_cmp", {135'd0, complete}, 136'd0);
        end
        enable = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            send_bit(pat[i]);
            if (i == 1) check("t4_not_done", {135'd0, complete}, 136'd0);
        end
        check("t4_complete", {135'd0, complete}, 136'd1);
        check("t4_out", out, 136'hAB5);
        enable = 1'b0;
        step();

        // ---- overlength: 140 beats, first 4 bits fall off ----
        framesize = 8'd140;
        enable    = 1'b1;
        step();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        pat = 136'hC3A50F1E2D3C4B5A69788796A5B4C3D2E1;
        for (int i = 135; i >= 0; i--) begin
            send_bit(pat[i]);
            if (i == 1) check("t5_not_done_139", {135'd0, complete}, 136'd0);
        end
        check("t5_complete", {135'd0, complete}, 136'd1);
        check("t5_out", out, 136'hC3A50F1E2D3C4B5A69788796A5B4C3D2E1);
        enable = 1'b0;
        step();

        // ---- framesize = 0: straight to DONE ----
        framesize = 8'd0;
        enable    = 1'b1;
        step();
        check("t5_zero_complete", {135'd0, complete}, 136'd1);
        check("t5_zero_busy", {135'd0, busy}, 136'd0);
        check("t5_zero_out", out, '0);
        enable = 1'b0;
        step();

        // ---- reset mid-SHIFT (enable still high) ----
        framesize = 8'd12;
        enable    = 1'b1;
        step();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        reset = 1'b1;
        step();
        check("t6_rst_shift_out", out, '0);
        check("t6_rst_shift_busy", {135'd0, busy}, 136'd0);
        check("t6_rst_shift_cmp", {135'd0, complete}, 136'd0);
        reset  = 1'b0;
        enable = 1'b0;
        step();
        check("t6_idle_busy", {135'd0, busy}, 136'd0);

        // ---- reset in DONE ----
        framesize = 8'd4;
        enable    = 1'b1;
        step();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("t6_done_cmp", {135'd0, complete}, 136'd1);
        check("t6_done_out", out, 136'hA);
        reset = 1'b1;
        step();
        check("t6_rst_done_out", out, '0);
        check("t6_rst_done_cmp", {135'd0, complete}, 136'd0);
        check("t6_rst_done_busy", {135'd0, busy}, 136'd0);

        // ---- fresh frame after reset ----
        reset     = 1'b0;
        framesize = 8'd12;
        enable    = 1'b1;
        step();
        pat = 136'hAB5;
        for (int i = 11; i >= 0; i--) send_bit(pat[i]);
        check("t6_fresh_cmp", {135'd0, complete}, 136'd1);
        check("t6_fresh_out", out, 136'hAB5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
